// File: rtl/int2flt_batch_seq.sv
// Batch sequencer: reads 16-bit operands from data memory, runs each through the
// int-to-float engine and writes the half-precision results back, little-endian.
module int2flt_batch_seq #(
  parameter logic [7:0]      SRC_BASE = 8'd0,
  parameter logic [7:0]      DST_BASE = 8'd64,
  parameter int              TO_W     = 11,
  parameter logic [TO_W-1:0] TIMEOUT  = 11'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [7:0]  count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cvt_start,
  output logic [15:0] cvt_opnd,
  input  logic        cvt_done,
  input  logic [15:0] cvt_result,
  output logic [2:0]  dbg_state
);

  // Engine handshake: cvt_start is a one-cycle request; cvt_done is a level that
  // qualifies cvt_result and is only honoured in WAIT, never in the START cycle,
  // so a done left high from the previous item cannot complete the next one.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_LO  = 3'd1,
    S_RD_HI  = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_WR_LO  = 3'd5,
    S_WR_HI  = 3'd6,
    S_FINISH = 3'd7
  } state_t;

  localparam logic [15:0] NAN_MARKER = 16'h7E00;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      idx_q, idx_d;
  logic [15:0]     opnd_q, opnd_d;
  logic [15:0]     res_q, res_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            err_q, err_d;

  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] idx_inc;

  // Byte offset of item i is 2i; everything is 8-bit so addresses wrap mod 256.
  assign src_addr = SRC_BASE + {idx_q[6:0], 1'b0};
  assign dst_addr = DST_BASE + {idx_q[6:0], 1'b0};
  assign idx_inc  = idx_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 8'd0;
      opnd_q  <= 16'd0;
      res_q   <= 16'd0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    wait_d    = wait_q;
    err_d     = err_q;
    busy      = 1'b1;
    done      = 1'b0;
    mem_addr  = 8'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'd0;
    cvt_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (go) begin
          err_d = 1'b0;
          idx_d = 8'd0;
          if (count != 8'd0) begin
            cnt_d   = count;
            state_d = S_RD_LO;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_RD_LO: begin
        mem_addr     = src_addr;
        mem_rd       = 1'b1;
        opnd_d[7:0]  = mem_rdata;
        state_d      = S_RD_HI;
      end
      S_RD_HI: begin
        mem_addr     = src_addr + 8'd1;
        mem_rd       = 1'b1;
        opnd_d[15:8] = mem_rdata;
        state_d      = S_START;
      end
      S_START: begin
        cvt_start = 1'b1;
        wait_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (cvt_done) begin
          res_d   = cvt_result;
          state_d = S_WR_LO;
        end else if (wait_q == TIMEOUT - 1'b1) begin
          // A stalled item still gets a result written so the batch keeps going.
          err_d   = 1'b1;
          res_d   = NAN_MARKER;
          state_d = S_WR_LO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WR_LO: begin
        mem_addr  = dst_addr;
        mem_wr    = 1'b1;
        mem_wdata = res_q[7:0];
        state_d   = S_WR_HI;
      end
      S_WR_HI: begin
        mem_addr  = dst_addr + 8'd1;
        mem_wr    = 1'b1;
        mem_wdata = res_q[15:8];
        idx_d     = idx_inc;
        state_d   = (idx_inc == cnt_q) ? S_FINISH : S_RD_LO;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign err       = err_q;
  assign cvt_opnd  = opnd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_int2flt_batch_seq.sv
// Bench for int2flt_batch_seq: byte memory and engine models, write scoreboard,
// table-driven single-item batches plus multi-item, timeout, reset and wrap cases.
module tb_int2flt_batch_seq;

  localparam int TIMEOUT = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- main instance ----------------
  logic        go = 1'b0;
  logic [7:0]  count = 8'd0;
  logic        busy, done, err;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
  logic        cvt_start, cvt_done;
  logic [15:0] cvt_opnd, cvt_result;
  logic [2:0]  dbg_state;

  int_to_dut_placeholder_unused_guard g_unused ();

  int2flt_batch_seq u_dut (
    .clk(clk), .reset(reset), .go(go), .count(count),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cvt_start(cvt_start), .cvt_opnd(cvt_opnd),
    .cvt_done(cvt_done), .cvt_result(cvt_result),
    .dbg_state(dbg_state)
  );

  // ---------------- wrap-around instance ----------------
  logic        w_go = 1'b0;
  logic [7:0]  w_count = 8'd0;
  logic        w_busy, w_done, w_err;
  logic [7:0]  w_mem_addr, w_mem_wdata, w_mem_rdata;
  logic        w_mem_rd, w_mem_wr;
  logic        w_cvt_start;
  logic [15:0] w_cvt_opnd, w_cvt_result;
  logic [2:0]  w_dbg_state;

  int2flt_batch_seq #(.SRC_BASE(8'd254), .DST_BASE(8'd252)) u_wrap (
    .clk(clk), .reset(reset), .go(w_go), .count(w_count),
    .busy(w_busy), .done(w_done), .err(w_err),
    .mem_addr(w_mem_addr), .mem_rd(w_mem_rd), .mem_wr(w_mem_wr),
    .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata),
    .cvt_start(w_cvt_start), .cvt_opnd(w_cvt_opnd),
    .cvt_done(1'b1), .cvt_result(w_cvt_result),
    .dbg_state(w_dbg_state)
  );

  // ---------------- memory models ----------------
  logic [7:0] mem [256];
  logic [7:0] w_mem [256];
  assign mem_rdata   = mem[mem_addr];
  assign w_mem_rdata = w_mem[w_mem_addr];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] = mem_wdata;
    if (w_mem_wr) w_mem[w_mem_addr] = w_mem_wdata;
  end

  // ---------------- engine models ----------------
  // Signed int16 to IEEE half, round to nearest even.
  function automatic logic [15:0] i2h(input logic [15:0] v);
    logic        s;
    logic [16:0] mag, m, rem, half;
    logic [4:0]  e;
    int          p, sh;
    s   = v[15];
    mag = s ? (17'h10000 - {1'b0, v}) : {1'b0, v};
    if (mag == 17'd0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 17; i++) if (mag[i]) p = i;
    e = 5'(p + 15);
    if (p <= 10) begin
      m = mag << (10 - p);
    end else begin
      sh   = p - 10;
      m    = mag >> sh;
      rem  = mag & ((17'd1 << sh) - 17'd1);
      half = 17'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 17'd1;
      if (m == 17'd2048) begin
        m = 17'd1024;
        e = e + 5'd1;
      end
    end
    return {s, e, m[9:0]};
  endfunction

  logic [7:0] lat = 8'd1;
  bit         never = 1'b0;
  logic [7:0] cd;

  // Done rises `lat` cycles after the start cycle and stays high until the next start.
  always @(posedge clk) begin
    if (reset) begin
      cvt_done   <= 1'b0;
      cvt_result <= 16'h0;
      cd         <= 8'd0;
    end else if (cvt_start) begin
      if (!never && lat <= 8'd1) begin
        cvt_done   <= 1'b1;
        cvt_result <= i2h(cvt_opnd);
        cd         <= 8'd0;
      end else begin
        cvt_done <= 1'b0;
        cd       <= never ? 8'd0 : lat - 8'd1;
      end
    end else if (cd == 8'd1) begin
      cd         <= 8'd0;
      cvt_done   <= 1'b1;
      cvt_result <= i2h(cvt_opnd);
    end else if (cd > 8'd1) begin
      cd <= cd - 8'd1;
    end
  end

  assign w_cvt_result = w_cvt_opnd ^ 16'h1234;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] w_exp_q[$];
  logic [7:0]  w_rd_exp_q[$];
  int n_start = 0, n_rd = 0, n_wr = 0, w_n_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (cvt_start) n_start++;
    if (mem_rd) n_rd++;
    if (mem_wr) begin
      n_wr++;
      chk("rd_wr_exclusive", {31'd0, mem_rd}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {16'd0, mem_addr, mem_wdata}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write", {16'd0, mem_addr, mem_wdata}, {16'd0, e});
      end
    end
    if (w_cvt_start) w_n_start++;
    if (w_mem_rd) begin
      if (w_rd_exp_q.size() == 0) chk("wrap_unexpected_read", {24'd0, w_mem_addr}, 32'hFFFF);
      else chk("wrap_read_addr", {24'd0, w_mem_addr}, {24'd0, w_rd_exp_q.pop_front()});
    end
    if (w_mem_wr) begin
      if (w_exp_q.size() == 0) begin
        chk("wrap_unexpected_write", {16'd0, w_mem_addr, w_mem_wdata}, 32'hFFFF);
      end else begin
        e = w_exp_q.pop_front();
        chk("wrap_write", {16'd0, w_mem_addr, w_mem_wdata}, {16'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_item(input int i, input logic [15:0] op, input logic [15:0] res,
                           input bit push);
    mem[8'(2 * i)]     = op[7:0];
    mem[8'(2 * i + 1)] = op[15:8];
    if (push) begin
      exp_q.push_back({8'(64 + 2 * i), res[7:0]});
      exp_q.push_back({8'(65 + 2 * i), res[15:8]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_err"},   {31'd0, err}, 32'd0);
    chk({tag, "_rd"},    {31'd0, mem_rd}, 32'd0);
    chk({tag, "_wr"},    {31'd0, mem_wr}, 32'd0);
    chk({tag, "_start"}, {31'd0, cvt_start}, 32'd0);
    chk({tag, "_addr"},  {24'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_opnd"},  {16'd0, cvt_opnd}, 32'd0);
    chk({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  // Pulse go and measure cycles from the accepting edge to the done cycle.
  task automatic run_batch(input logic [7:0] n, input logic [7:0] l, input bit nev,
                           input int exp_lat, input bit go_again);
    int k, s0, r0, w0;
    lat = l;
    never = nev;
    s0 = n_start; r0 = n_rd; w0 = n_wr;
    @(negedge clk);
    count = n;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    k = 1;
    while (!done && k < 5000) begin
      go = (go_again && k == 3);
      @(posedge clk); #1;
      k++;
    end
    go = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", k, exp_lat);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("start_count", n_start - s0, {24'd0, n});
    chk("read_count", n_rd - r0, 2 * n);
    chk("write_count", n_wr - w0, 2 * n);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [15:0] op;
    logic [7:0]  l;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k;
    vecs[0] = '{16'h0001, 8'd3, 16'h3C00};
    vecs[1] = '{16'h0000, 8'd1, 16'h0000};
    vecs[2] = '{16'h8000, 8'd2, 16'hF800};
    vecs[3] = '{16'h7FFF, 8'd1, 16'h7800};
    vecs[4] = '{16'hFFFF, 8'd4, 16'hBC00};
    vecs[5] = '{16'h0800, 8'd1, 16'h6800};
    vecs[6] = '{16'(0), 8'd1, 16'h0000};
    vecs[6].op  = 16'($urandom_range(1, 2047));
    vecs[6].l   = 8'($urandom_range(1, 9));
    vecs[6].res = i2h(vecs[6].op);
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      w_mem[i] = 8'h00;
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // single-item batches from the table
    for (int i = 0; i < 7; i++) begin
      load_item(0, vecs[i].op, vecs[i].res, 1'b1);
      run_batch(8'd1, vecs[i].l, 1'b0, 6 + int'(vecs[i].l), 1'b0);
      chk("mem_lo", {24'd0, mem[64]}, {24'd0, vecs[i].res[7:0]});
      chk("mem_hi", {24'd0, mem[65]}, {24'd0, vecs[i].res[15:8]});
      chk("err_clear", {31'd0, err}, 32'd0);
    end

    // three items, with a stray go mid-batch that must be ignored
    load_item(0, 16'h0000, 16'h0000, 1'b1);
    load_item(1, 16'h8000, 16'hF800, 1'b1);
    load_item(2, 16'h7FFF, 16'h7800, 1'b1);
    run_batch(8'd3, 8'd2, 1'b0, 3 * 7 + 1, 1'b1);

    // empty batch
    run_batch(8'd0, 8'd1, 1'b0, 1, 1'b0);

    // engine never responds: both items time out
    load_item(0, 16'h1111, 16'h7E00, 1'b1);
    load_item(1, 16'h2222, 16'h7E00, 1'b1);
    run_batch(8'd2, 8'd1, 1'b1, 2 * (5 + TIMEOUT) + 1, 1'b0);
    chk("err_after_timeout", {31'd0, err}, 32'd1);
    run_batch(8'd0, 8'd1, 1'b0, 1, 1'b0);
    chk("err_cleared_by_go", {31'd0, err}, 32'd0);

    // reset during WAIT of item 1
    for (int a = 66; a < 70; a++) mem[a] = 8'hA5;
    load_item(0, 16'h0003, 16'h4200, 1'b1);
    load_item(1, 16'h0004, 16'h4400, 1'b0);
    load_item(2, 16'h0005, 16'h4500, 1'b0);
    lat = 8'd20;
    never = 1'b0;
    @(negedge clk);
    count = 8'd3;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    k = 1;
    while (k < 35) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_wait_before_reset", {29'd0, dbg_state}, 32'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 66; a < 70; a++) chk("untouched_after_reset", {24'd0, mem[a]}, 32'hA5);
    chk("reset_queue_drained", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    load_item(0, 16'h0005, 16'h4500, 1'b1);
    run_batch(8'd1, 8'd1, 1'b0, 7, 1'b0);

    // address wrap on the second instance
    w_mem[254] = 8'h34; w_mem[255] = 8'h12;
    w_mem[0]   = 8'h78; w_mem[1]   = 8'h56;
    w_rd_exp_q = '{8'd254, 8'd255, 8'd0, 8'd1};
    w_exp_q    = '{16'hFC00, 16'hFD00, 16'hFE4C, 16'hFF44};
    @(negedge clk);
    w_count = 8'd2;
    w_go = 1'b1;
    @(posedge clk); #1;
    w_go = 1'b0;
    k = 1;
    while (!w_done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wrap_latency", k, 13);
    @(posedge clk); #1;
    chk("wrap_idle", {31'd0, w_busy}, 32'd0);
    chk("wrap_state", {29'd0, w_dbg_state}, 32'd0);
    chk("wrap_err", {31'd0, w_err}, 32'd0);
    chk("wrap_starts", w_n_start, 2);
    chk("wrap_reads_drained", w_rd_exp_q.size(), 0);
    chk("wrap_writes_drained", w_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// Empty module keeping the bench free of dangling instances; holds no logic.
module int_to_dut_placeholder_unused_guard;
endmodule
